pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
// - Central stall/flush controller for the 5-stage MIPS pipeline: load-use hazard stall, taken-branch flush, data-memory wait handshake.
// - Sits beside IF_ID/ID_EX/EX_MEM/MEM_WB and drives their write-enable, flush and bubble controls.
// - Owns the MEM-stage memory request FSM with a bounded-wait timeout.
// PARAMETERS
// - MEM_TIMEOUT  16  consecutive un-acked Mem_Req cycles before the access is abandoned (>=2)
// - CNT_W        5   wait-counter width; must hold MEM_TIMEOUT
// PORTS
// - Clk               in   1   clock, all state on posedge
// - Rst               in   1   synchronous, active-high reset
// - IF_ID_Rs          in   5   rs of instruction in ID
// - IF_ID_Rt          in   5   rt of instruction in ID
// - ID_EX_Rt          in   5   destination of instruction in EX
// - ID_EX_MemRead     in   1   instruction in EX is a load
// - EX_BranchTaken    in   1   branch/jump resolved taken in EX
// - EX_MEM_MemRead    in   1   MEM-stage load
// - EX_MEM_MemWrite   in   1   MEM-stage store
// - Mem_Ack           in   1   data memory completes access this cycle
// - Mem_Req           out  1   access request to data memory
// - PCWrite           out  1   PC update enable
// - IF_ID_Write       out  1   IF_ID load enable
// - IF_ID_Flush       out  1   IF_ID loads zeros
// - ID_EX_Flush       out  1   ID_EX loads zero controls (bubble)
// - Pipe_Hold         out  1   ID_EX and EX_MEM keep contents
// - MEM_WB_Bubble     out  1   MEM_WB loads zero RegWrite/MemtoReg/WriteEnable
// - Mem_Err           out  1   sticky timeout flag
// - Stall_Count       out  32  stall-cycle counter (see CONFIGURATION)
// BEHAVIOUR
// - FSM states: IDLE, WAIT. Reset: IDLE, wait cnt=0, Mem_Err=0, Stall_Count=0.
// - Outputs combinational from state + inputs; during Rst: PCWrite=IF_ID_Write=1, all others 0.
// - Access = EX_MEM_MemRead|EX_MEM_MemWrite. Mem_Req = Access in IDLE, 1 in WAIT.
// - IDLE: Access & Mem_Ack -> zero-wait, no stall, stay IDLE. Access & !Mem_Ack -> memstall=1, go WAIT, cnt<=1.
// - WAIT: Mem_Ack -> memstall=0, pipeline advances this cycle, go IDLE, cnt<=0.
//   !Mem_Ack & cnt==MEM_TIMEOUT-1 -> timeout: memstall=0, MEM_WB_Bubble=1, Mem_Err<=1, go IDLE, cnt<=0.
//   else memstall=1, cnt<=cnt+1.
// - memstall=1: PCWrite=0, IF_ID_Write=0, Pipe_Hold=1, MEM_WB_Bubble=1, both flushes 0 (branch re-evaluated after release).
// - Else, EX_BranchTaken: IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1 (branch beats load-use).
// - Else load-use = ID_EX_MemRead & ID_EX_Rt!=0 & (ID_EX_Rt==IF_ID_Rs | ID_EX_Rt==IF_ID_Rt):
//   PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; exactly one bubble per hazard.
// - Otherwise PCWrite=IF_ID_Write=1, all others 0.
// - Mem_Ack in IDLE with no Access ignored. Mem_Err cleared only by Rst.
// - Rst mid-WAIT: next cycle IDLE, Mem_Req=0, Mem_Err=0.
// CONFIGURATION
// - PIPE_PERF_CNT_EN defined: Stall_Count += 1 each cycle PCWrite==0 (not in Rst); saturates at 32'hFFFF_FFFF.
// - Not defined: no counter logic, Stall_Count tied to 32'b0.
// TESTING
// - Store in MEM, Mem_Ack=1 same cycle -> Mem_Req=1 one cycle, PCWrite=1 throughout, state stays IDLE.
// - Load in MEM, Mem_Ack after 3 cycles -> PCWrite=0/Pipe_Hold=1/MEM_WB_Bubble=1 for 3 cycles, released on ack cycle.
// - Load in EX rt=5, ID rs=5 -> one cycle PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; ID_EX_Rt=0 -> no stall.
// - Load-use + EX_BranchTaken same cycle -> IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1.
// - Mem_Ack never, MEM_TIMEOUT=16 -> stall 15 cycles, 16th cycle bubble+release, Mem_Err=1 until Rst.
// - With PIPE_PERF_CNT_EN: previous 3-wait load -> Stall_Count=3; without macro -> 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller with the MEM-stage request FSM and a bounded memory wait.
// Optional stall-cycle counter is enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  IF_ID_Rs,
  input  logic [4:0]  IF_ID_Rt,
  input  logic [4:0]  ID_EX_Rt,
  input  logic        ID_EX_MemRead,
  input  logic        EX_BranchTaken,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic        Mem_Ack,
  output logic        Mem_Req,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        Pipe_Hold,
  output logic        MEM_WB_Bubble,
  output logic        Mem_Err,
  output logic [31:0] Stall_Count
);

  typedef enum logic [0:0] {StIdle, StWait} stateT;

  stateT            stateQ;
  logic [CNT_W-1:0] cntQ;
  logic             errQ;

  logic access;
  logic lastWait;
  logic loadUse;
  logic memStall;
  logic timeout;

  assign access   = EX_MEM_MemRead | EX_MEM_MemWrite;
  assign lastWait = (cntQ == CNT_W'(MEM_TIMEOUT - 1));
  assign loadUse  = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                    ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));

  always_comb begin
    Mem_Req  = 1'b0;
    memStall = 1'b0;
    timeout  = 1'b0;
    if (!Rst) begin
      unique case (stateQ)
        StIdle: begin
          Mem_Req  = access;
          memStall = access & ~Mem_Ack;
        end
        StWait: begin
          Mem_Req = 1'b1;
          if (!Mem_Ack) begin
            if (lastWait) timeout  = 1'b1;
            else          memStall = 1'b1;
          end
        end
      endcase
    end
  end

  // Memory stall dominates; otherwise branch flush beats load-use.
  always_comb begin
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    Pipe_Hold     = 1'b0;
    MEM_WB_Bubble = 1'b0;
    if (!Rst) begin
      if (memStall) begin
        PCWrite       = 1'b0;
        IF_ID_Write   = 1'b0;
        Pipe_Hold     = 1'b1;
        MEM_WB_Bubble = 1'b1;
      end else begin
        MEM_WB_Bubble = timeout;
        if (EX_BranchTaken) begin
          IF_ID_Flush = 1'b1;
          ID_EX_Flush = 1'b1;
        end else if (loadUse) begin
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
          ID_EX_Flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stateQ <= StIdle;
      cntQ   <= '0;
      errQ   <= 1'b0;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (access && !Mem_Ack) begin
            stateQ <= StWait;
            cntQ   <= CNT_W'(1);
          end
        end
        StWait: begin
          if (Mem_Ack) begin
            stateQ <= StIdle;
            cntQ   <= '0;
          end else if (lastWait) begin
            stateQ <= StIdle;
            cntQ   <= '0;
            errQ   <= 1'b1;
          end else begin
            cntQ <= cntQ + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign Mem_Err = errQ & ~Rst;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stallCntQ;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stallCntQ <= '0;
    end else if (!PCWrite && (stallCntQ != 32'hFFFF_FFFF)) begin
      stallCntQ <= stallCntQ + 32'd1;
    end
  end

  assign Stall_Count = Rst ? 32'd0 : stallCntQ;
`else
  assign Stall_Count = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: table of single-cycle hazard cases plus memory wait,
// timeout and reset sequences, checked through an expected-result queue.
module tb_pipe_hazard_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [4:0]  IF_ID_Rs, IF_ID_Rt, ID_EX_Rt;
  logic        ID_EX_MemRead, EX_BranchTaken, EX_MEM_MemRead, EX_MEM_MemWrite, Mem_Ack;
  logic        Mem_Req, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
  logic        Pipe_Hold, MEM_WB_Bubble, Mem_Err;
  logic [31:0] Stall_Count;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .Clk(Clk), .Rst(Rst),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .ID_EX_Rt(ID_EX_Rt),
    .ID_EX_MemRead(ID_EX_MemRead), .EX_BranchTaken(EX_BranchTaken),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite), .Mem_Ack(Mem_Ack),
    .Mem_Req(Mem_Req), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .Pipe_Hold(Pipe_Hold),
    .MEM_WB_Bubble(MEM_WB_Bubble), .Mem_Err(Mem_Err), .Stall_Count(Stall_Count)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs, rt, exRt;
    logic       exLoad, br, mRd, mWr, ack;
  } inT;

  typedef struct {
    inT         in;
    logic [7:0] exp;
    string      name;
  } vecT;

  typedef struct {
    logic [7:0]  exp;
    logic [31:0] cnt;
    string       name;
  } sbT;

  // Expected bits: {Mem_Req, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
  //                 Pipe_Hold, MEM_WB_Bubble, Mem_Err}
  localparam logic [7:0] Norm    = 8'h60;
  localparam logic [7:0] MStall  = 8'h86;
  localparam logic [7:0] Branch  = 8'h78;
  localparam logic [7:0] LdUse   = 8'h08;
  localparam logic [7:0] ReqNorm = 8'hE0;
  localparam logic [7:0] TmOut   = 8'hE2;

  sbT          sbQ[$];
  int          nTests = 0;
  int          nFail  = 0;
  logic [31:0] expCnt = 32'd0;
  vecT         tbl[10];
  inT          idle;

  function automatic inT mkIn(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] exRt, input logic exLoad, input logic br,
                              input logic mRd, input logic mWr, input logic ack);
    inT v;
    v.rst = rst; v.rs = rs; v.rt = rt; v.exRt = exRt; v.exLoad = exLoad;
    v.br = br; v.mRd = mRd; v.mWr = mWr; v.ack = ack;
    return v;
  endfunction

  task automatic step(input inT in, input logic [7:0] exp, input string name);
    sbT         e;
    logic [7:0] act;
    Rst = in.rst; IF_ID_Rs = in.rs; IF_ID_Rt = in.rt; ID_EX_Rt = in.exRt;
    ID_EX_MemRead = in.exLoad; EX_BranchTaken = in.br;
    EX_MEM_MemRead = in.mRd; EX_MEM_MemWrite = in.mWr; Mem_Ack = in.ack;
    e.exp  = exp;
    e.name = name;
`ifdef PIPE_PERF_CNT_EN
    e.cnt = in.rst ? 32'd0 : expCnt;
    if (in.rst) expCnt = 32'd0;
    else if (!exp[6] && expCnt != 32'hFFFF_FFFF) expCnt = expCnt + 32'd1;
`else
    e.cnt = 32'd0;
`endif
    sbQ.push_back(e);
    @(negedge Clk);
    e   = sbQ.pop_front();
    act = {Mem_Req, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
           Pipe_Hold, MEM_WB_Bubble, Mem_Err};
    nTests++;
    if (act !== e.exp) begin
      nFail++;
      $display("FAIL %s: outputs got %b want %b", e.name, act, e.exp);
    end
    nTests++;
    if (Stall_Count !== e.cnt) begin
      nFail++;
      $display("FAIL %s.cnt: Stall_Count got %0d want %0d", e.name, Stall_Count, e.cnt);
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle = mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0] = '{mkIn(0, 5, 7, 7, 0, 0, 0, 0, 0), Norm,   "noLoad"};
    tbl[1] = '{mkIn(0, 5, 3, 5, 1, 0, 0, 0, 0), LdUse,  "luRs"};
    tbl[2] = '{mkIn(0, 2, 7, 7, 1, 0, 0, 0, 0), LdUse,  "luRt"};
    tbl[3] = '{mkIn(0, 0, 0, 0, 1, 0, 0, 0, 0), Norm,   "luR0"};
    tbl[4] = '{mkIn(0, 5, 5, 5, 0, 0, 0, 0, 0), Norm,   "noLoadMatch"};
    tbl[5] = '{mkIn(0, 1, 2, 3, 1, 0, 0, 0, 0), Norm,   "loadNoMatch"};
    tbl[6] = '{mkIn(0, 5, 3, 5, 1, 1, 0, 0, 0), Branch, "luBranch"};
    tbl[7] = '{mkIn(0, 0, 0, 0, 0, 1, 0, 0, 0), Branch, "branch"};
    tbl[8] = '{mkIn(0, 0, 0, 0, 0, 0, 0, 0, 1), Norm,   "ackIdle"};
    tbl[9] = '{mkIn(0, 9, 9, 9, 1, 0, 0, 0, 1), LdUse,  "luAckIdle"};

    // Reset with busy inputs: outputs forced to the reset pattern.
    step(mkIn(1, 5, 5, 5, 1, 1, 1, 0, 0), Norm, "reset0");
    step(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 0), Norm, "reset1");

    for (int i = 0; i < 10; i++) step(tbl[i].in, tbl[i].exp, tbl[i].name);

    // Zero-wait store: one request cycle, FSM stays idle.
    step(mkIn(0, 0, 0, 0, 0, 0, 0, 1, 1), ReqNorm, "storeZeroWait");
    step(idle, Norm, "afterStore");

    // Load acked on the fourth cycle; branch held off while memory stalls.
    step(mkIn(0, 0, 0, 0, 0, 0, 1, 0, 0), MStall,  "ld3w1");
    step(mkIn(0, 0, 0, 0, 0, 0, 1, 0, 0), MStall,  "ld3w2");
    step(mkIn(0, 0, 0, 0, 0, 1, 1, 0, 0), MStall,  "ld3w3Br");
    step(mkIn(0, 0, 0, 0, 0, 0, 1, 0, 1), ReqNorm, "ld3Ack");
    step(idle, Norm, "afterLd3");

    // Never-acked load: 15 stall cycles, then bubble + release, error sticky.
    for (int i = 0; i < 15; i++) step(mkIn(0, 0, 0, 0, 0, 0, 1, 0, 0), MStall, "tmStall");
    step(mkIn(0, 0, 0, 0, 0, 0, 1, 0, 0), TmOut, "timeout");
    step(idle, Norm | 8'h01, "errSticky0");
    step(mkIn(0, 5, 3, 5, 1, 0, 0, 0, 0), LdUse | 8'h01, "errSticky1");
    step(idle, Norm | 8'h01, "errSticky2");

    // Reset while waiting clears the FSM and the error flag.
    step(mkIn(0, 0, 0, 0, 0, 0, 1, 0, 0), MStall | 8'h01, "rstWait1");
    step(mkIn(0, 0, 0, 0, 0, 0, 1, 0, 0), MStall | 8'h01, "rstWait2");
    step(mkIn(1, 0, 0, 0, 0, 0, 1, 0, 0), Norm, "rstMidWait");
    step(idle, Norm, "afterRst");
    step(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 1), Norm, "afterRstAck");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
